// File: rtl/lif_pkg.sv
// Shared constants and types for the LIF spike encoder.
// Event layout depends on LIF_EVT_STATE_EN (defined: {ts, state}; undefined: {ts}).
package lif_pkg;

    localparam int TS_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT_TS = 2'd1,
        BEAT_ST = 2'd2
    } evt_beat_e;

`ifdef LIF_EVT_STATE_EN
    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [7:0]      state;
    } lif_evt_t;
`else
    typedef struct packed {
        logic [TS_W-1:0] ts;
    } lif_evt_t;
`endif

endpackage

// File: rtl/lif_spike_encoder_if.sv
// Byte stream carrying encoded spike packets to the readout logic.
interface lif_spike_encoder_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lif_evt_fifo.sv
// Register FIFO for spike events; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module lif_evt_fifo
    import lif_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  lif_evt_t din,
    output lif_evt_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    lif_evt_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lif_spike_encoder.sv
// Timestamps LIF spikes, queues them and streams them out as byte packets.
// LIF_EVT_STATE_EN adds the membrane-state byte as a second beat of each packet.
//
// state   | meaning
// IDLE    | no packet in the output register
// BEAT_TS | presenting the timestamp byte
// BEAT_ST | presenting the membrane-state byte
module lif_spike_encoder
    import lif_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       spike_in,
    input  logic [7:0]                 state_in,
    input  logic                       ts_clr,
    lif_spike_encoder_if.master        evt_out,
    output logic                       fifo_full,
    output logic                       overflow
);

    logic [TS_W-1:0] ts;
    lif_evt_t        evt_in;
    lif_evt_t        head;
    lif_evt_t        pkt_q;
    lif_evt_t        pkt_d;
    evt_beat_e       state_q;
    evt_beat_e       state_d;
    logic            push;
    logic            pop;
    logic            empty;
    logic            next_pkt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ts <= '0;
        else if (ts_clr) ts <= '0;
        else if (ena)    ts <= ts + TS_W'(1);
    end

    assign push = ena & spike_in;

`ifdef LIF_EVT_STATE_EN
    assign evt_in = '{ts: ts, state: state_in};
`else
    logic unused_state;
    assign unused_state = ^state_in;
    assign evt_in = '{ts: ts};
`endif

    lif_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (evt_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (empty)
    );

    // A drop only happens when the full FIFO is not being popped on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           overflow <= 1'b0;
        else if (push && fifo_full && !pop)   overflow <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        pop      = 1'b0;
        next_pkt = 1'b0;
        case (state_q)
            IDLE:    next_pkt = 1'b1;
            BEAT_TS: if (evt_out.out_ready) begin
`ifdef LIF_EVT_STATE_EN
                state_d = BEAT_ST;
`else
                next_pkt = 1'b1;
`endif
            end
            BEAT_ST: if (evt_out.out_ready) next_pkt = 1'b1;
            default: state_d = IDLE;
        endcase
        // Loading the next head on the last accept keeps packets back-to-back.
        if (next_pkt) begin
            if (!empty) begin
                pop     = 1'b1;
                pkt_d   = head;
                state_d = BEAT_TS;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign evt_out.out_valid = (state_q != IDLE);

    always_comb begin
        evt_out.out_data = '0;
        case (state_q)
            BEAT_TS: evt_out.out_data = pkt_q.ts;
`ifdef LIF_EVT_STATE_EN
            BEAT_ST: evt_out.out_data = pkt_q.state;
`else
            BEAT_ST: evt_out.out_data = pkt_q.ts;
`endif
            default: evt_out.out_data = '0;
        endcase
    end

endmodule
